// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a gate window of GATE_CYCLES clocks.
// Define FREQ_METER_BCD_EN to add a sequential double-dabble BCD converter on the result.
module freq_meter #(
  parameter int GATE_CYCLES = 12_000_000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DIGITS      = 5
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                sig_in,
  output logic                gate,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic                valid
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid
`endif
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  if (GATE_CYCLES < 2 || SYNC_STAGES < 2 || CNT_W < 1 || DIGITS < 1) begin : g_param_check
    $error("freq_meter: illegal parameter value");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Returns {saturated, result}; result sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] a, input logic inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{CNT_W{1'b0}}, inc};
    if (s[CNT_W]) sat_inc = {1'b1, {CNT_W{1'b1}}};
    else          sat_inc = s;
  endfunction

  // Stage p0: input synchronizer and edge detect (runs regardless of en)
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Stage p1: gate window, edge accumulation and result latch
  state_t             state_q, state_d;
  logic [GW-1:0]      gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               valid_q, valid_d;
  logic [CNT_W:0]     acc_res;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_acc_d  = ovf_acc_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    acc_res    = sat_inc(edge_cnt_q, rise);
    unique case (state_q)
      S_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        ovf_acc_d  = 1'b0;
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) begin
          // Abort wins even in the last cycle of the window: nothing is published.
          state_d    = S_IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
          count_d    = acc_res[CNT_W-1:0];
          overflow_d = ovf_acc_q | acc_res[CNT_W];
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_acc_d  = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
          edge_cnt_d = acc_res[CNT_W-1:0];
          ovf_acc_d  = ovf_acc_q | acc_res[CNT_W];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_acc_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign gate     = (state_q == S_RUN);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;

`ifdef FREQ_METER_BCD_EN
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + CNT_W;
  localparam int CW    = $clog2(CNT_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]      BCD_MAX = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] ALL9    = {DIGITS{4'h9}};

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (t[CNT_W + 4*i +: 4] >= 4'd5) t[CNT_W + 4*i +: 4] = t[CNT_W + 4*i +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // Stage p2: BCD conversion of the latched result
  logic [SR_W-1:0]  dd_q, dd_d, dd_next;
  logic [CW-1:0]    conv_cnt_q, conv_cnt_d;
  logic             clip_q, clip_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;

  always_comb begin
    dd_d        = dd_q;
    conv_cnt_d  = conv_cnt_q;
    clip_d      = clip_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    dd_next     = dd_step(dd_q);
    if (valid_q) begin
      // A fresh result restarts any conversion already in flight.
      dd_d       = {{BCD_W{1'b0}}, count_q};
      conv_cnt_d = CW'(CNT_W);
      clip_d     = overflow_q | (64'(count_q) > BCD_MAX);
    end else if (conv_cnt_q != '0) begin
      dd_d       = dd_next;
      conv_cnt_d = conv_cnt_q - CW'(1);
      if (conv_cnt_q == CW'(1)) begin
        bcd_d       = clip_q ? ALL9 : dd_next[CNT_W +: BCD_W];
        bcd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dd_q        <= '0;
      conv_cnt_q  <= '0;
      clip_q      <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      dd_q        <= dd_d;
      conv_cnt_q  <= conv_cnt_d;
      clip_q      <= clip_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed self-checking bench for freq_meter: two 100-cycle-gate instances (16-bit and 4-bit counters),
// plus two converter instances when FREQ_METER_BCD_EN is defined.
module tb_freq_meter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic sig_man = 1'b0;
  logic sig_gen = 1'b0;
  logic gen_on = 1'b0;
  logic sig_in;
  int   half = 5;

  int n_pass = 0;
  int n_total = 0;
  int gate_drops = 0;
  logic mon_gate = 1'b0;

  assign sig_in = gen_on ? sig_gen : sig_man;

  logic        gate_a, ovf_a, vld_a;
  logic [15:0] count_a;
  logic        gate_b, ovf_b, vld_b;
  logic [3:0]  count_b;
  logic [3:0]  vld_v;

`ifdef FREQ_METER_BCD_EN
  logic [19:0] bcd_a, bcd_b, bcd_c;
  logic [11:0] bcd_d;
  logic        bcdv_a, bcdv_b, bcdv_c, bcdv_d;
  logic        gate_c, ovf_c, vld_c, gate_d, ovf_d, vld_d;
  logic [15:0] count_c, count_d;
  assign vld_v = {vld_d, vld_c, vld_b, vld_a};
`else
  assign vld_v = {2'b00, vld_b, vld_a};
`endif

  freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2), .DIGITS(5)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .sig_in(sig_in),
    .gate(gate_a), .count(count_a), .overflow(ovf_a), .valid(vld_a)
`ifdef FREQ_METER_BCD_EN
    , .bcd(bcd_a), .bcd_valid(bcdv_a)
`endif
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2), .DIGITS(5)) u_dut4 (
    .clk(clk), .rstn(rstn), .en(en), .sig_in(sig_in),
    .gate(gate_b), .count(count_b), .overflow(ovf_b), .valid(vld_b)
`ifdef FREQ_METER_BCD_EN
    , .bcd(bcd_b), .bcd_valid(bcdv_b)
`endif
  );

`ifdef FREQ_METER_BCD_EN
  freq_meter #(.GATE_CYCLES(4936), .CNT_W(16), .SYNC_STAGES(2), .DIGITS(5)) u_bcd5 (
    .clk(clk), .rstn(rstn), .en(en), .sig_in(sig_in),
    .gate(gate_c), .count(count_c), .overflow(ovf_c), .valid(vld_c),
    .bcd(bcd_c), .bcd_valid(bcdv_c)
  );

  freq_meter #(.GATE_CYCLES(2100), .CNT_W(16), .SYNC_STAGES(2), .DIGITS(3)) u_bcd3 (
    .clk(clk), .rstn(rstn), .en(en), .sig_in(sig_in),
    .gate(gate_d), .count(count_d), .overflow(ovf_d), .valid(vld_d),
    .bcd(bcd_d), .bcd_valid(bcdv_d)
  );
`endif

  always #5 clk = ~clk;

  // Square-wave source: toggles every 'half' clocks, changed on falling edges.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (ph >= half - 1) begin
        sig_gen = ~sig_gen;
        ph = 0;
      end else begin
        ph++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_gate && !gate_a) gate_drops++;
  end

  task automatic wait_vld(input int idx, input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (vld_v[idx]) ok = 1'b1;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL wait_valid[%0d]: no valid within %0d cycles", idx, budget);
    end
  endtask

  task automatic test_reset();
    bit ok;
    int cyc, nv, ng;
    #12;
    n_total++;
    if ({gate_a, count_a, ovf_a, vld_a} !== 19'd0) $display("FAIL reset_state: got gate=%b count=%0d ovf=%b valid=%b, want all 0", gate_a, count_a, ovf_a, vld_a);
    else n_pass++;
`ifdef FREQ_METER_BCD_EN
    n_total++;
    if ({bcd_c, bcdv_c} !== 21'd0) $display("FAIL reset_bcd: got bcd=%h bcd_valid=%b, want 0", bcd_c, bcdv_c);
    else n_pass++;
`endif
    @(negedge clk);
    rstn = 1'b1;
    half = 5;
    gen_on = 1'b1;
    @(negedge clk);
    en = 1'b1;
    wait_vld(0, 150, ok, cyc);
    wait_vld(0, 150, ok, cyc);
    n_total++;
    if (count_a !== 16'd10) $display("FAIL pre_reset_count: got %0d, want 10", count_a);
    else n_pass++;
    #2;
    rstn = 1'b0;
    #1;
    n_total++;
    if ({gate_a, count_a, ovf_a, vld_a, gate_b, count_b, ovf_b, vld_b} !== 26'd0)
      $display("FAIL async_reset: got gate=%b count=%0d ovf=%b valid=%b count4=%0d, want all 0", gate_a, count_a, ovf_a, vld_a, count_b);
    else n_pass++;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    nv = 0;
    ng = 0;
    repeat (500) begin
      @(posedge clk);
      #1;
      if (vld_a || vld_b) nv++;
      if (gate_a || gate_b) ng++;
    end
    n_total++;
    if (nv !== 0) $display("FAIL idle_valid: got %0d valid pulses, want 0", nv);
    else n_pass++;
    n_total++;
    if (ng !== 0) $display("FAIL idle_gate: got %0d gate-high cycles, want 0", ng);
    else n_pass++;
  endtask

  task automatic test_square();
    bit ok;
    int cyc;
    @(negedge clk);
    en = 1'b1;
    wait_vld(0, 150, ok, cyc);
    n_total++;
    if (cyc !== 101) $display("FAIL first_valid_latency: got %0d cycles, want 101", cyc);
    else n_pass++;
    n_total++;
    if (count_a !== 16'd10 || ovf_a !== 1'b0) $display("FAIL square_first: got count=%0d ovf=%b, want 10/0", count_a, ovf_a);
    else n_pass++;
    mon_gate = 1'b1;
    for (int w = 0; w < 3; w++) begin
      wait_vld(0, 150, ok, cyc);
      n_total++;
      if (cyc !== 100 || count_a !== 16'd10 || ovf_a !== 1'b0)
        $display("FAIL square_window%0d: got period=%0d count=%0d ovf=%b, want 100/10/0", w, cyc, count_a, ovf_a);
      else n_pass++;
    end
    mon_gate = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (vld_a !== 1'b0) $display("FAIL valid_width: got valid=%b one cycle later, want 0", vld_a);
    else n_pass++;
    n_total++;
    if (gate_drops !== 0) $display("FAIL gate_continuous: got %0d gate-low cycles, want 0", gate_drops);
    else n_pass++;
  endtask

  task automatic test_saturate();
    bit ok;
    int cyc;
    half = 2;
    wait_vld(1, 150, ok, cyc);
    wait_vld(1, 150, ok, cyc);
    n_total++;
    if (count_b !== 4'd15 || ovf_b !== 1'b1) $display("FAIL sat_count4: got count=%0d ovf=%b, want 15/1", count_b, ovf_b);
    else n_pass++;
    n_total++;
    if (count_a !== 16'd25 || ovf_a !== 1'b0) $display("FAIL period4_count16: got count=%0d ovf=%b, want 25/0", count_a, ovf_a);
    else n_pass++;
    half = 5;
    wait_vld(1, 150, ok, cyc);
    wait_vld(1, 150, ok, cyc);
    n_total++;
    if (count_b !== 4'd10 || ovf_b !== 1'b0) $display("FAIL sat_recover4: got count=%0d ovf=%b, want 10/0", count_b, ovf_b);
    else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    int cyc, nv;
    wait_vld(0, 150, ok, cyc);
    repeat (50) @(negedge clk);
    en = 1'b0;
    nv = 0;
    repeat (150) begin
      @(posedge clk);
      #1;
      if (vld_a) nv++;
    end
    n_total++;
    if (nv !== 0 || count_a !== 16'd10 || gate_a !== 1'b0)
      $display("FAIL abort_mid: got valids=%0d count=%0d gate=%b, want 0/10/0", nv, count_a, gate_a);
    else n_pass++;
    // Abort in the last window cycle with a 20-clock period, so a wrong latch would show 5.
    half = 10;
    repeat (30) @(negedge clk);
    en = 1'b1;
    repeat (100) @(negedge clk);
    n_total++;
    if (gate_a !== 1'b1) $display("FAIL gate_before_L: got %b, want 1", gate_a);
    else n_pass++;
    en = 1'b0;
    nv = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (vld_a) nv++;
    end
    n_total++;
    if (nv !== 0 || count_a !== 16'd10) $display("FAIL abort_at_L: got valids=%0d count=%0d, want 0/10", nv, count_a);
    else n_pass++;
    half = 5;
    repeat (20) @(negedge clk);
    en = 1'b1;
    wait_vld(0, 150, ok, cyc);
    n_total++;
    if (cyc !== 101 || count_a !== 16'd10) $display("FAIL reenable: got latency=%0d count=%0d, want 101/10", cyc, count_a);
    else n_pass++;
  endtask

  task automatic test_level();
    bit ok;
    int cyc;
    logic [15:0] c1, c2;
    @(negedge clk);
    sig_man = 1'b1;
    gen_on = 1'b0;
    en = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b1;
    for (int w = 0; w < 2; w++) begin
      wait_vld(0, 150, ok, cyc);
      n_total++;
      if (count_a !== 16'd0) $display("FAIL level_high_window%0d: got count=%0d, want 0", w, count_a);
      else n_pass++;
    end
    for (int j = 96; j <= 99; j++) begin
      @(negedge clk);
      en = 1'b0;
      sig_man = 1'b0;
      repeat (10) @(negedge clk);
      en = 1'b1;
      c1 = 16'hffff;
      c2 = 16'hffff;
      fork
        begin
          repeat (j + 1) @(negedge clk);
          sig_man = 1'b1;
          repeat (3) @(negedge clk);
          sig_man = 1'b0;
        end
        begin
          bit ok1;
          int cy1;
          wait_vld(0, 150, ok1, cy1);
          c1 = count_a;
          wait_vld(0, 150, ok1, cy1);
          c2 = count_a;
        end
      join
      n_total++;
      if (32'(c1) + 32'(c2) !== 32'd1) $display("FAIL pulse_at_L_off%0d: got windows %0d+%0d, want total 1", j, c1, c2);
      else n_pass++;
    end
  endtask

`ifdef FREQ_METER_BCD_EN
  task automatic test_bcd();
    bit ok;
    int cyc;
    @(negedge clk);
    en = 1'b0;
    half = 1;
    gen_on = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;
    wait_vld(0, 150, ok, cyc);
    cyc = 0;
    while (!bcdv_a && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_total++;
    if (cyc !== 17 || bcd_a !== 20'h00050) $display("FAIL bcd_50: got delay=%0d bcd=%h, want 17/00050", cyc, bcd_a);
    else n_pass++;
    wait_vld(1, 150, ok, cyc);
    cyc = 0;
    while (!bcdv_b && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_total++;
    if (cyc !== 5 || ovf_b !== 1'b1 || bcd_b !== 20'h99999) $display("FAIL bcd_ovf: got delay=%0d ovf=%b bcd=%h, want 5/1/99999", cyc, ovf_b, bcd_b);
    else n_pass++;
    wait_vld(2, 5200, ok, cyc);
    n_total++;
    if (count_c !== 16'd2468 || ovf_c !== 1'b0) $display("FAIL bcd_count2468: got count=%0d ovf=%b, want 2468/0", count_c, ovf_c);
    else n_pass++;
    cyc = 0;
    while (!bcdv_c && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_total++;
    if (cyc !== 17 || bcd_c !== 20'h02468) $display("FAIL bcd_2468: got delay=%0d bcd=%h, want 17/02468", cyc, bcd_c);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if (bcd_c !== 20'h02468 || bcdv_c !== 1'b0) $display("FAIL bcd_hold: got bcd=%h bcd_valid=%b, want 02468/0", bcd_c, bcdv_c);
    else n_pass++;
    wait_vld(3, 2300, ok, cyc);
    n_total++;
    if (count_d !== 16'd1050) $display("FAIL bcd3_count: got %0d, want 1050", count_d);
    else n_pass++;
    cyc = 0;
    while (!bcdv_d && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    n_total++;
    if (cyc !== 17 || bcd_d !== 12'h999) $display("FAIL bcd_clip: got delay=%0d bcd=%h, want 17/999", cyc, bcd_d);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_square();
    test_saturate();
    test_abort();
    test_level();
`ifdef FREQ_METER_BCD_EN
    test_bcd();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of an asynchronous slow input, such as a divided clock or an external pulse train. It counts rising edges of sig_in over a fixed gate window of GATE_CYCLES system clocks. At the end of each window it latches the count and pulses valid. Intended to feed the 7-segment display path, and to loop-check divided clocks on the Alhambra II (12 MHz clk).

Parameters:
GATE_CYCLES, 12_000_000, gate window length in clk cycles (>=2; default = 1 s at 12 MHz)
CNT_W, 16, width of edge counter and result
SYNC_STAGES, 2, synchronizer flops on sig_in (>=2)
DIGITS, 5, BCD digits (used only with FREQ_METER_BCD_EN)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  measurement enable
sig_in  in  1  asynchronous signal to measure
gate  out  1  high while a window is running
count  out  CNT_W  edge count of last completed window (saturated)
overflow  out  1  last window saturated count
valid  out  1  one-cycle pulse: count/overflow just updated
bcd  out  4*DIGITS  BCD of count (FREQ_METER_BCD_EN only)
bcd_valid  out  1  one-cycle pulse: bcd updated (FREQ_METER_BCD_EN only)

Behaviour:
- Reset (rstn low, async): sync flops, prev flop, gate counter, edge counter = 0. Outputs gate, count, overflow, valid, bcd and bcd_valid = 0. State IDLE.
- Sync chain and prev flop run every cycle regardless of en. rise = sync_out & ~prev. Latency from a sig_in edge to rise is SYNC_STAGES+1 clk. Max measurable frequency is about clk/2. A level that is already high at enable produces no edge.
- State machine has two states, IDLE and RUN.
- IDLE (en=0): gate=0, gate_cnt=0, edge_cnt=0, ovf_acc=0. IDLE -> RUN on the first clock edge with en=1.
- RUN: gate=1. gate_cnt increments by 1 each cycle. rise increments edge_cnt. At 2^CNT_W-1 the counter saturates and ovf_acc is set.
- End of window, in the cycle where gate_cnt == GATE_CYCLES-1 (call it cycle L):
  - On the following clock edge, count <= saturating(edge_cnt + rise), overflow <= ovf_acc | saturation on this add, and valid <= 1 for one cycle.
  - On that same edge, gate_cnt, edge_cnt and ovf_acc clear. The next window starts with no gap; gate stays 1.
- en low in RUN: abort. Return to IDLE next edge. No valid. count/overflow keep the last completed result.
- en low exactly in cycle L: abort takes priority. No valid and no update.
- count and overflow change only together with valid.
- rstn mid-window: everything returns to reset values immediately.

Optional Feature:
Macro FREQ_METER_BCD_EN.
- Defined:
  - A sequential shift-add-3 (double dabble) converter starts on valid, loading count. It takes CNT_W cycles; bcd_valid pulses CNT_W+1 cycles after valid.
  - bcd holds its value between conversions.
  - If overflow=1 or count > 10^DIGITS-1, bcd = all 9s.
  - A new valid during a conversion restarts it with the new count.
  - Reset clears the converter.
- Undefined: bcd and bcd_valid ports and all converter logic are absent. Core behaviour is identical.

Test Plan:
1. Assert rstn=0 mid-run with en=1 -> all outputs 0 asynchronously. Release with en=0 for 500 cycles -> gate=0, valid never pulses.
2. GATE_CYCLES=100, en=1, sig_in square wave of period 10 clk -> valid every 100 cycles, count=10, overflow=0, gate continuously 1.
3. GATE_CYCLES=100, CNT_W=4, sig_in period 4 (25 edges) -> count=15, overflow=1. Then period 10 -> next window count=10, overflow=0.
4. GATE_CYCLES=100, period 10, drop en at cycle 50 of the second window -> no valid, count stays 10. Re-raise en -> next valid exactly 101 cycles after the en=1 edge.
5. sig_in held high before en rises, then constant -> count=0 each window. A single sig_in pulse of 3 clk landing in cycle L is counted in exactly one window, never both.
6. FREQ_METER_BCD_EN, GATE_CYCLES=4936, CNT_W=16, DIGITS=5, sig_in period 2 -> count=2468, bcd=0x02468, bcd_valid 17 cycles after valid. Then CNT_W=20, period 1-edge-per-2 with GATE_CYCLES=250000 (125000 edges) -> bcd=0x99999.
